// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
//   Signal bundle between the timekeeping core (master) and the multiplexed
//   seven-segment driver (slave).
//
//   display     packed digits, digit i = display[4i+3:4i], digit 0 rightmost
//   load        request to capture display at the next frame boundary
//   blink_mask  1 = digit i blinks
//   dp_mask     1 = decimal point lit on digit i
//   blank_lead  1 = suppress leading zeros
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point
//   digit_sel   one-hot digit enable
//   frame_done  1-cycle pulse after each frame wrap
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] display;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lead;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output display, load, blink_mask, dp_mask, blank_lead,
    input  seg, dp, digit_sel, frame_done
  );

  modport slave (
    input  display, load, blink_mask, dp_mask, blank_lead,
    output seg, dp, digit_sel, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed seven-segment driver. Digits are lit round-robin, each for
//   SCAN_DIV clocks. New display values are staged and only copied into the
//   shadow register at a frame wrap, so a frame never mixes old and new digits.
//   Supports leading-zero blanking, per-digit blink and decimal points.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    slave side of sevenseg_scan_driver_if (inputs: display, load,
//          blink_mask, dp_mask, blank_lead; outputs: seg, dp, digit_sel,
//          frame_done)
//
// Parameters:
//   NUM_DIGITS  digits scanned (>=2); must match the interface parameter
//   SCAN_DIV    clocks each digit stays lit (>=1)
//   BLINK_DIV   clocks per blink half-period (>=1)
//   ACTIVE_LOW  1 = seg/dp/digit_sel asserted low
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_driver_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_POL = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  // Active-high a..g pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] staging;
  logic                    pend;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_ph;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    frame_done_q;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              cur_digit;
  logic                    lead_blank;
  logic                    blink_blank;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   sel_n;

  assign tick = (scan_cnt == SCAN_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // zero_above[i] = 1 when shadow digits NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    logic run;
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path can leave it unassigned and infer a latch.
    run        = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run && (shadow[4*i +: 4] == 4'h0);
      zero_above[i] = run;
    end
  end

  always_comb begin
    cur_digit   = shadow[4*idx +: 4];
    lead_blank  = bus.blank_lead && (idx != '0) && zero_above[idx];
    blink_blank = bus.blink_mask[idx] && blink_ph;
    seg_n       = (lead_blank || blink_blank) ? 7'h00 : hex7(cur_digit);
    // Lead blanking keeps the decimal point; a blink phase hides it too.
    dp_n        = bus.dp_mask[idx] && !blink_blank;
    sel_n       = SEL_ONE << idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      staging      <= '0;
      pend         <= 1'b0;
      scan_cnt     <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
      seg_q        <= SEG_POL;
      dp_q         <= ACTIVE_LOW;
      sel_q        <= SEL_POL;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (tick) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // Shadow only moves at the frame boundary; a load seen in the wrap
      // cycle itself goes straight through, otherwise the newest staged
      // value is used.
      if (wrap) begin
        if (bus.load) begin
          shadow <= bus.display;
        end else if (pend) begin
          shadow <= staging;
        end
        pend <= 1'b0;
      end else if (bus.load) begin
        staging <= bus.display;
        pend    <= 1'b1;
      end

      frame_done_q <= wrap;
      seg_q        <= seg_n ^ SEG_POL;
      dp_q         <= dp_n ^ ACTIVE_LOW;
      sel_q        <= sel_n ^ SEL_POL;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Two driver instances share one stimulus stream:
//     dut_a: 4 digits, SCAN_DIV=4, BLINK_DIV=8, active-low pins
//     dut_b: 4 digits, SCAN_DIV=1, BLINK_DIV=3, active-high pins
//   A behavioural model derives the scan position and blink phase from the
//   number of clocks since reset, tracks the frame-synchronous load rule and
//   predicts every output each cycle. Directed checks with hand-computed
//   values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  localparam int N    = 4;
  localparam int SD_A = 4;
  localparam int BD_A = 8;
  localparam int SD_B = 1;
  localparam int BD_B = 3;

  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4*N-1:0] display;
  logic           load;
  logic [N-1:0]   blink_mask;
  logic [N-1:0]   dp_mask;
  logic           blank_lead;

  sevenseg_scan_driver_if #(.NUM_DIGITS(N)) bus_a ();
  sevenseg_scan_driver_if #(.NUM_DIGITS(N)) bus_b ();

  assign bus_a.display    = display;
  assign bus_a.load       = load;
  assign bus_a.blink_mask = blink_mask;
  assign bus_a.dp_mask    = dp_mask;
  assign bus_a.blank_lead = blank_lead;
  assign bus_b.display    = display;
  assign bus_b.load       = load;
  assign bus_b.blink_mask = blink_mask;
  assign bus_b.dp_mask    = dp_mask;
  assign bus_b.blank_lead = blank_lead;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD_A), .BLINK_DIV(BD_A), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD_B), .BLINK_DIV(BD_B), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model --
  int           m_n      [2];
  logic [4*N-1:0] m_shadow [2];
  logic [4*N-1:0] m_stage  [2];
  bit           m_pend   [2];
  logic [6:0]   e_seg    [2];
  logic         e_dp     [2];
  logic [N-1:0] e_sel    [2];
  logic         e_fd     [2];

  function automatic int sd_of(input int k);
    return (k == 0) ? SD_A : SD_B;
  endfunction

  function automatic int bd_of(input int k);
    return (k == 0) ? BD_A : BD_B;
  endfunction

  function automatic bit al_of(input int k);
    return (k == 0);
  endfunction

  task automatic model_reset(input int k);
    m_n[k]      = 0;
    m_shadow[k] = '0;
    m_stage[k]  = '0;
    m_pend[k]   = 1'b0;
    e_seg[k]    = al_of(k) ? 7'h7F : 7'h00;
    e_dp[k]     = al_of(k);
    e_sel[k]    = al_of(k) ? '1 : '0;
    e_fd[k]     = 1'b0;
  endtask

  // One clock edge: outputs reflect the position and inputs before the edge.
  task automatic model_edge(input int k);
    int         pos;
    bit         ph;
    bit         lb;
    bit         bb;
    logic [6:0] s;
    logic       d;
    logic [N-1:0] sel;
    bit         wrap;
    pos  = (m_n[k] / sd_of(k)) % N;
    ph   = ((m_n[k] / bd_of(k)) % 2) == 1;
    lb   = blank_lead && (pos != 0) && ((m_shadow[k] >> (4 * pos)) == 0);
    bb   = blink_mask[pos] && ph;
    s    = (lb || bb) ? 7'h00 : HEX7[m_shadow[k][4*pos +: 4]];
    d    = dp_mask[pos] && !bb;
    sel  = N'(1 << pos);
    wrap = (m_n[k] % (sd_of(k) * N)) == (sd_of(k) * N - 1);
    e_seg[k] = al_of(k) ? ~s   : s;
    e_dp[k]  = al_of(k) ? ~d   : d;
    e_sel[k] = al_of(k) ? ~sel : sel;
    e_fd[k]  = wrap;
    if (wrap) begin
      if (load)         m_shadow[k] = display;
      else if (m_pend[k]) m_shadow[k] = m_stage[k];
      m_pend[k] = 1'b0;
    end else if (load) begin
      m_stage[k] = display;
      m_pend[k]  = 1'b1;
    end
    m_n[k]++;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or posedge reset);
      for (int k = 0; k < 2; k++) begin
        if (reset) model_reset(k);
        else       model_edge(k);
      end
    end
  end

  // ------------------------------------------------------ per-cycle compare --
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("dut_a_cycle", {bus_a.seg, bus_a.dp, bus_a.digit_sel, bus_a.frame_done},
              {e_seg[0], e_dp[0], e_sel[0], e_fd[0]});
        check("dut_b_cycle", {bus_b.seg, bus_b.dp, bus_b.digit_sel, bus_b.frame_done},
              {e_seg[1], e_dp[1], e_sel[1], e_fd[1]});
      end
    end
  end

  // ------------------------------------------------------------- stimulus --
  // Advance k clock edges and land 1 time unit after the last one.
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    display    = '0;
    load       = 1'b0;
    blink_mask = '0;
    dp_mask    = '0;
    blank_lead = 1'b0;

    cyc(2);
    chk_en = 1'b1;
    check("rst_a_seg", bus_a.seg, 7'h7F);
    check("rst_a_dp",  bus_a.dp, 1'b1);
    check("rst_a_sel", bus_a.digit_sel, 4'hF);
    check("rst_a_fd",  bus_a.frame_done, 1'b0);
    check("rst_b_all", {bus_b.seg, bus_b.dp, bus_b.digit_sel}, 12'h000);

    // Load 1234 with reset release; it appears after the first frame.
    reset   = 1'b0;
    display = 16'h1234;
    load    = 1'b1;
    cyc(1);                               // edge 0
    load    = 1'b0;
    cyc(15);                              // edge 15: first wrap
    check("a_first_wrap_fd", bus_a.frame_done, 1'b1);
    cyc(1);                               // edge 16: digit 0 = '4'
    check("a_d0_seg", bus_a.seg, 7'h19);
    check("a_d0_sel", bus_a.digit_sel, 4'b1110);
    check("a_fd_low", bus_a.frame_done, 1'b0);
    cyc(4);                               // edge 20: digit 1 = '3'
    check("a_d1_seg", bus_a.seg, 7'h30);
    check("a_d1_sel", bus_a.digit_sel, 4'b1101);

    // Two loads mid-frame: last one wins at the next wrap.
    display = 16'h5678;
    load    = 1'b1;
    cyc(1);                               // edge 21
    load    = 1'b0;
    cyc(3);                               // edge 24
    display = 16'h9ABC;
    load    = 1'b1;
    cyc(1);                               // edge 25
    load    = 1'b0;
    display = 16'h0000;
    cyc(3);                               // edge 28: still old frame, '1'
    check("a_midframe_seg", bus_a.seg, 7'h79);
    check("a_midframe_sel", bus_a.digit_sel, 4'b0111);
    cyc(4);                               // edge 32: new frame digit 0 = 'C'
    check("a_newframe_seg", bus_a.seg, 7'h46);

    // Leading-zero blanking.
    blank_lead = 1'b1;
    display    = 16'h0000;
    load       = 1'b1;
    cyc(1);                               // edge 33
    load       = 1'b0;
    cyc(15);                              // edge 48: digit 0 shows '0'
    check("a_lz_d0", bus_a.seg, 7'h40);
    cyc(4);                               // edge 52: digit 1 blank
    check("a_lz_d1", bus_a.seg, 7'h7F);
    display = 16'h0105;
    load    = 1'b1;
    cyc(1);                               // edge 53
    load    = 1'b0;
    cyc(11);                              // edge 64: '5'
    check("a_0105_d0", bus_a.seg, 7'h12);
    cyc(4);                               // edge 68: inner zero kept
    check("a_0105_d1", bus_a.seg, 7'h40);
    cyc(8);                               // edge 76: leading zero blank
    check("a_0105_d3", bus_a.seg, 7'h7F);
    check("a_0105_d3_sel", bus_a.digit_sel, 4'b0111);

    // Blink and decimal points.
    blank_lead = 1'b0;
    display    = 16'h1234;
    load       = 1'b1;
    blink_mask = 4'b0010;
    dp_mask    = 4'b0100;
    cyc(1);                               // edge 77
    load       = 1'b0;
    cyc(11);                              // edge 88: digit 2, blink phase 1
    check("a_dp_d2_dp",  bus_a.dp, 1'b0);
    check("a_dp_d2_seg", bus_a.seg, 7'h24);
    blink_mask = 4'b0110;
    cyc(16);                              // edge 104: digit 2 blinking off
    check("a_blink_seg", bus_a.seg, 7'h7F);
    check("a_blink_dp",  bus_a.dp, 1'b1);
    check("a_blink_sel", bus_a.digit_sel, 4'b1011);

    // Reset mid-frame with a pending load.
    display = 16'h4321;
    load    = 1'b1;
    cyc(1);                               // edge 105
    load    = 1'b0;
    reset   = 1'b1;
    #1;
    check("a_async_rst", {bus_a.seg, bus_a.dp, bus_a.digit_sel, bus_a.frame_done},
          {7'h7F, 1'b1, 4'hF, 1'b0});
    check("b_async_rst", {bus_b.seg, bus_b.dp, bus_b.digit_sel, bus_b.frame_done}, 13'h0);
    cyc(1);
    reset      = 1'b0;
    blink_mask = '0;
    dp_mask    = '0;
    cyc(1);                               // edge 0 after reset
    check("a_post_rst_seg", {bus_a.seg, bus_a.dp}, {7'h40, 1'b1});
    check("a_post_rst_sel", bus_a.digit_sel, 4'b1110);
    check("b_post_rst", {bus_b.seg, bus_b.digit_sel}, {7'h3F, 4'b0001});
    cyc(3);                               // edge 3: dut_b wraps each 4 clocks
    check("b_wrap_fd",  bus_b.frame_done, 1'b1);
    check("b_wrap_sel", bus_b.digit_sel, 4'b1000);
    cyc(1);                               // edge 4
    check("b_fd_low",   bus_b.frame_done, 1'b0);
    check("b_sel_back", bus_b.digit_sel, 4'b0001);
    cyc(12);                              // edge 16: pending value discarded
    check("a_pend_gone", bus_a.seg, 7'h40);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
